// File: rtl/vga_timing_decoder_if.sv
// Timing-stream bundle between a VGA sync source (master) and the decoder (slave)
// that rebuilds pixel/line counters and lock status from it.
interface vga_timing_decoder_if #(
  parameter int CW = 11
) ();
  logic          hsync_in;
  logic          vsync_in;
  logic          hblnk_in;
  logic          vblnk_in;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic [CW-1:0] h_total;
  logic [CW-1:0] v_total;
  logic          locked;
  logic          pixel_valid;
  logic          err;

  modport master (
    output hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  hcount, vcount, h_total, v_total, locked, pixel_valid, err
  );

  modport slave (
    input  hsync_in, vsync_in, hblnk_in, vblnk_in,
    output hcount, vcount, h_total, v_total, locked, pixel_valid, err
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// Rebuilds hcount/vcount from an incoming sync/blank stream, measures line and
// frame length, and declares lock once the geometry repeats for LOCK_FRAMES frames.
module vga_timing_decoder #(
  parameter int CW          = 11,
  parameter int LOCK_FRAMES = 2,
  parameter int MAX_COUNT   = 2047
) (
  input  logic                pclk,
  input  logic                rst,
  vga_timing_decoder_if.slave vif
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_COUNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic          hblnk_q, vblnk_q, hsync_q;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [CW-1:0] h_total_q, h_total_d;
  logic [CW-1:0] v_total_q, v_total_d;
  logic [CW-1:0] h_ref_q, h_ref_d;
  logic [CW-1:0] v_ref_q, v_ref_d;
  logic [3:0]    match_cnt_q, match_cnt_d;
  logic          hc_valid_q, hc_valid_d;
  logic          fs_seen_q, fs_seen_d;
  logic          href_valid_q, href_valid_d;
  logic          vref_valid_q, vref_valid_d;
  logic          line_bad_q, line_bad_d;
  logic          locked_q, locked_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic          err_q, err_d;

  logic          ls, fs;
  logic [CW-1:0] hc_inc, vc_inc;
  logic          sync_fault, line_len_bad, frame_len_bad, hc_sat;

  // Line start is the falling edge of hblank; a frame start needs vblank to fall on that same edge.
  assign ls            = hblnk_q & ~vif.hblnk_in;
  assign fs            = ls & vblnk_q & ~vif.vblnk_in;
  assign hc_inc        = hc_q + CNT_ONE;
  assign vc_inc        = vc_q + CNT_ONE;
  assign sync_fault    = hsync_q & ~hblnk_q;
  assign line_len_bad  = ls & href_valid_q & (hc_inc != h_ref_q);
  assign frame_len_bad = fs & (vc_inc != v_ref_q);
  assign hc_sat        = ~ls & (hc_q != CNT_MAX) & (hc_inc == CNT_MAX);

  always_comb begin
    hc_d       = ls ? '0 : ((hc_q == CNT_MAX) ? CNT_MAX : hc_inc);
    hc_valid_d = hc_valid_q | ls;
    if (fs) begin
      vc_d = '0;
    end else if (ls && (vc_q != CNT_MAX)) begin
      vc_d = vc_inc;
    end else begin
      vc_d = vc_q;
    end
    h_total_d = (ls && hc_valid_q) ? hc_inc : h_total_q;
    v_total_d = (fs && fs_seen_q) ? vc_inc : v_total_q;
    fs_seen_d = fs_seen_q | fs;

    state_d      = state_q;
    h_ref_d      = h_ref_q;
    v_ref_d      = v_ref_q;
    match_cnt_d  = match_cnt_q;
    href_valid_d = href_valid_q;
    vref_valid_d = vref_valid_q;
    line_bad_d   = line_bad_q;
    locked_d     = locked_q;
    err_d        = sync_fault;

    case (state_q)
      SEARCH: begin
        locked_d    = 1'b0;
        match_cnt_d = '0;
        if (fs) begin
          state_d      = ACQUIRE;
          href_valid_d = 1'b0;
          vref_valid_d = 1'b0;
          line_bad_d   = 1'b0;
        end
      end
      ACQUIRE: begin
        if (ls && !href_valid_q) begin
          h_ref_d      = hc_inc;
          href_valid_d = 1'b1;
        end else if (line_len_bad) begin
          line_bad_d = 1'b1;
        end
        // The line closed by this frame start counts toward the frame's consistency too.
        if (fs) begin
          line_bad_d = 1'b0;
          if (!vref_valid_q) begin
            v_ref_d      = vc_inc;
            vref_valid_d = 1'b1;
          end else if (!line_bad_q && !line_len_bad && !frame_len_bad) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LOCK_TGT) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_cnt_d = '0;
            v_ref_d     = vc_inc;
          end
        end
      end
      LOCKED: begin
        if (line_len_bad || frame_len_bad || hc_sat || sync_fault) begin
          err_d       = 1'b1;
          state_d     = SEARCH;
          locked_d    = 1'b0;
          match_cnt_d = '0;
        end
      end
      default: begin
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
    endcase

    pixel_valid_d = locked_d & ~vif.hblnk_in & ~vif.vblnk_in;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= SEARCH;
      hblnk_q       <= 1'b1;
      vblnk_q       <= 1'b1;
      hsync_q       <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      h_ref_q       <= '0;
      v_ref_q       <= '0;
      match_cnt_q   <= '0;
      hc_valid_q    <= 1'b0;
      fs_seen_q     <= 1'b0;
      href_valid_q  <= 1'b0;
      vref_valid_q  <= 1'b0;
      line_bad_q    <= 1'b0;
      locked_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hblnk_q       <= vif.hblnk_in;
      vblnk_q       <= vif.vblnk_in;
      hsync_q       <= vif.hsync_in;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      h_ref_q       <= h_ref_d;
      v_ref_q       <= v_ref_d;
      match_cnt_q   <= match_cnt_d;
      hc_valid_q    <= hc_valid_d;
      fs_seen_q     <= fs_seen_d;
      href_valid_q  <= href_valid_d;
      vref_valid_q  <= vref_valid_d;
      line_bad_q    <= line_bad_d;
      locked_q      <= locked_d;
      pixel_valid_q <= pixel_valid_d;
      err_q         <= err_d;
    end
  end

  assign vif.hcount      = hc_q;
  assign vif.vcount      = vc_q;
  assign vif.h_total     = h_total_q;
  assign vif.v_total     = v_total_q;
  assign vif.locked      = locked_q;
  assign vif.pixel_valid = pixel_valid_q;
  assign vif.err         = err_q;

endmodule
